mmio_interconnect: RTL and testbench

Parametrised memory-mapped interconnect between the picorv32 native memory port and up to `NUM_SLAVES` peripherals. It replaces hard-coded per-address select compares, the OR-ed ready and the rdata priority mux with a table-driven decoder and a registered, single-outstanding transaction engine. A per-transaction timeout guarantees completion when an address is unmapped or a slave never answers. The block sits between `cpu` and `sram`, timer, buttons, LEDs and the game registers.

---
 rtl/mmio_pkg.sv | 26 ++
 rtl/mmio_addr_decode.sv | 33 +++
 rtl/mmio_interconnect.sv | 171 +++++++++++++++++
 tb/tb_mmio_interconnect.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Purpose: shared types and constants for the mmio_interconnect slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, timeout default read data, counter width and
// error status register field offsets.
package mmio_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Read data returned when a transaction is forced to complete.
  localparam logic [31:0] MMIO_DEFAULT_RDATA = 32'hDEAD_BEEF;

  // Timeout counter width; TIMEOUT_CYCLES is capped at 255 so it never wraps.
  localparam int TIMEOUT_W = 8;

  // Error status register layout: {fault_addr[23:0], err_count[7:0]}.
  localparam int ERR_COUNT_LSB = 0;
  localparam int ERR_COUNT_W   = 8;
  localparam int ERR_FADDR_LSB = 8;
  localparam int ERR_FADDR_W   = 24;

endpackage

// File: rtl/mmio_addr_decode.sv
// Purpose: table-driven address decoder, one-hot select with lowest-index priority.
// Latency: combinational (0 cycles).
// Backpressure: none; pure function of the address.
// Ports: i_addr (32) address to decode; o_sel (NUM_SLAVES) one-hot select;
//        o_hit asserted when any slave matches.
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int                         NUM_SLAVES = 8,
  parameter logic [NUM_SLAVES*32-1:0]   BASE_ADDRS = '0,
  parameter logic [NUM_SLAVES*32-1:0]   ADDR_MASKS = '0
) (
  input  logic [31:0]           i_addr,
  output logic [NUM_SLAVES-1:0] o_sel,
  output logic                  o_hit
);

  // Walk from the highest index down so the lowest matching index is the
  // last one written and therefore wins on overlapping windows.
  always_comb begin
    o_sel = '0;
    o_hit = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((i_addr & ADDR_MASKS[32*i +: 32]) ==
          (BASE_ADDRS[32*i +: 32] & ADDR_MASKS[32*i +: 32])) begin
        o_sel    = '0;
        o_sel[i] = 1'b1;
        o_hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_interconnect.sv
// Purpose: picorv32 native port to NUM_SLAVES peripherals, single outstanding access with timeout.
// Latency: request to m_ready is 2 cycles minimum, TIMEOUT_CYCLES+1 for an unmapped/silent slave.
// Backpressure: new request accepted only in IDLE; at most one transaction per 3 cycles.
// Ports: clk, reset (sync, active-high); m_valid/m_addr/m_wdata/m_wstrb in, m_ready/m_rdata out;
//        s_sel/s_addr/s_wdata/s_wstrb out (registered), s_ready/s_rdata in (per slave, packed).
// Option: MMIO_ERR_STATUS_EN adds an error status register at ERR_ADDR.
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int                       NUM_SLAVES     = 8,
  parameter logic [NUM_SLAVES*32-1:0] BASE_ADDRS     = '0,
  parameter logic [NUM_SLAVES*32-1:0] ADDR_MASKS     = '0,
  parameter int                       TIMEOUT_CYCLES = 16,
  parameter logic [31:0]              DEFAULT_RDATA  = MMIO_DEFAULT_RDATA,
  parameter logic [31:0]              ERR_ADDR       = 32'h8000_0040
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       m_valid,
  input  logic [31:0]                m_addr,
  input  logic [31:0]                m_wdata,
  input  logic [3:0]                 m_wstrb,
  output logic                       m_ready,
  output logic [31:0]                m_rdata,
  output logic [NUM_SLAVES-1:0]      s_sel,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wstrb,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata
);

`ifdef MMIO_ERR_STATUS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t                r_state, w_state_nxt;
  logic [TIMEOUT_W-1:0]  r_cnt;
  logic [NUM_SLAVES-1:0] r_sel;
  logic [31:0]           r_addr, r_wdata, r_rdata;
  logic [3:0]            r_wstrb;
  logic                  r_ready;
  logic                  r_err_sel;

  logic [NUM_SLAVES-1:0] w_dec_sel;
  logic                  w_dec_hit;
  logic                  w_err_hit;
  logic                  w_sel_ready;
  logic                  w_timeout;
  logic                  w_done;
  logic [31:0]           w_slave_rdata;
  logic [31:0]           w_err_rdata;

  mmio_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDRS (BASE_ADDRS),
    .ADDR_MASKS (ADDR_MASKS)
  ) u_decode (
    .i_addr (m_addr),
    .o_sel  (w_dec_sel),
    .o_hit  (w_dec_hit)
  );

  // The internal register shadows any external window covering ERR_ADDR.
  assign w_err_hit   = ERR_EN && (m_addr == ERR_ADDR);
  // r_sel is only non-zero in ACCESS, so masking also ignores stray readies.
  assign w_sel_ready = |(s_ready & r_sel);
  assign w_timeout   = (r_cnt == TMO_LAST);
  assign w_done      = r_err_sel | w_sel_ready | w_timeout;

  always_comb begin
    w_slave_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel[i]) w_slave_rdata = w_slave_rdata | s_rdata[32*i +: 32];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (m_valid) w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_done)  w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sel     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_ready   <= 1'b0;
      r_err_sel <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (m_valid) begin
            r_addr    <= m_addr;
            r_wdata   <= m_wdata;
            r_wstrb   <= m_wstrb;
            r_sel     <= (w_dec_hit && !w_err_hit) ? w_dec_sel : '0;
            r_err_sel <= w_err_hit;
            r_cnt     <= '0;
          end
        end
        S_ACCESS: begin
          if (w_done) begin
            // Strobes were already presented to the slave; a timeout simply
            // completes the CPU side without any rollback.
            r_sel     <= '0;
            r_err_sel <= 1'b0;
            r_ready   <= 1'b1;
            r_rdata   <= r_err_sel   ? w_err_rdata   :
                         w_sel_ready ? w_slave_rdata : DEFAULT_RDATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MMIO_ERR_STATUS_EN
  logic [ERR_COUNT_W-1:0] r_err_count;
  logic [ERR_FADDR_W-1:0] r_fault_addr;
  logic                   w_tmo_evt;

  assign w_tmo_evt = (r_state == S_ACCESS) && w_timeout && !w_sel_ready && !r_err_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_count  <= '0;
      r_fault_addr <= '0;
    end else if ((r_state == S_ACCESS) && r_err_sel && (r_wstrb != 4'h0)) begin
      r_err_count  <= '0;
      r_fault_addr <= '0;
    end else if (w_tmo_evt) begin
      if (r_err_count != {ERR_COUNT_W{1'b1}}) r_err_count <= r_err_count + 1'b1;
      r_fault_addr <= r_addr[ERR_FADDR_W-1:0];
    end
  end

  always_comb begin
    w_err_rdata = '0;
    w_err_rdata[ERR_COUNT_LSB +: ERR_COUNT_W] = r_err_count;
    w_err_rdata[ERR_FADDR_LSB +: ERR_FADDR_W] = r_fault_addr;
  end
`else
  assign w_err_rdata = '0;
`endif

  assign m_ready = r_ready;
  assign m_rdata = r_rdata;
  assign s_sel   = r_sel;
  assign s_addr  = r_addr;
  assign s_wdata = r_wdata;
  assign s_wstrb = r_wstrb;

endmodule

// File: tb/tb_mmio_interconnect.sv
// Purpose: directed self-checking bench for mmio_interconnect.
// Latency: checks cycle-exact completion against hand-derived counts.
// Backpressure: slave readiness is scripted per transaction.
module tb_mmio_interconnect;

  localparam int NS = 8;
  localparam logic [NS*32-1:0] BASES = {
    32'hF000_0070, 32'hF000_0060, 32'h8000_0024, 32'hF000_0040,
    32'hF000_0030, 32'h8000_0020, 32'h8000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASKS = {
    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
    32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFE_0000};

  logic           clk = 1'b0;
  logic           reset;
  logic           m_valid;
  logic [31:0]    m_addr, m_wdata;
  logic [3:0]     m_wstrb;
  logic           m_ready;
  logic [31:0]    m_rdata;
  logic [NS-1:0]  s_sel;
  logic [31:0]    s_addr, s_wdata;
  logic [3:0]     s_wstrb;
  logic [NS-1:0]  s_ready;
  logic [NS*32-1:0] s_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mmio_interconnect #(
    .NUM_SLAVES     (NS),
    .BASE_ADDRS     (BASES),
    .ADDR_MASKS     (MASKS),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m_valid (m_valid),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_ready (m_ready),
    .m_rdata (m_rdata),
    .s_sel   (s_sel),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_ready (s_ready),
    .s_rdata (s_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request at cycle 0 and observes until the cycle after m_ready
  // (or a 40-cycle bound). rdy_idx < 0 means no slave ever answers.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int rdy_idx,
                         input int rdy_cyc, input logic [31:0] rd_val,
                         output int ready_cyc, output logic [31:0] rdata,
                         output int sel_cycles, output logic [NS-1:0] sel_or,
                         output int pulses, output logic [31:0] wd_seen,
                         output logic [3:0] ws_seen);
    ready_cyc  = -1;
    rdata      = '0;
    sel_cycles = 0;
    sel_or     = '0;
    pulses     = 0;
    wd_seen    = '0;
    ws_seen    = '0;
    m_valid = 1'b1; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (s_sel != '0) begin
        sel_cycles++;
        sel_or  = sel_or | s_sel;
        wd_seen = s_wdata;
        ws_seen = s_wstrb;
      end
      if (m_ready) begin
        pulses++;
        if (ready_cyc < 0) begin
          ready_cyc = cyc;
          rdata     = m_rdata;
        end
      end
      m_valid = 1'b0;
      s_ready = '0;
      s_rdata = '0;
      if (rdy_idx >= 0 && cyc >= rdy_cyc) begin
        s_ready[rdy_idx]          = 1'b1;
        s_rdata[32*rdy_idx +: 32] = rd_val;
      end
      if (ready_cyc >= 0 && cyc == ready_cyc + 1) break;
    end
    s_ready = '0;
    s_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_ready = '0; s_rdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if ({m_ready, m_rdata, s_sel, s_addr, s_wdata, s_wstrb} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got m_ready=%0b m_rdata=%h s_sel=%h s_addr=%h s_wdata=%h s_wstrb=%h, want all 0",
               m_ready, m_rdata, s_sel, s_addr, s_wdata, s_wstrb);
    end
  endtask

  task automatic test_sram_read();
    int rc, sc, np; logic [31:0] rd, wd; logic [NS-1:0] so; logic [3:0] ws;
    run_txn(32'h0000_0100, 32'h0, 4'h0, 0, 2, 32'h1234_5678, rc, rd, sc, so, np, wd, ws);
    n_checks++;
    if (rc !== 3) begin n_fail++; $display("FAIL sram_latency: got %0d want 3", rc); end
    n_checks++;
    if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL sram_rdata: got %h want 12345678", rd); end
    n_checks++;
    if (sc !== 2 || so !== 8'h01) begin
      n_fail++; $display("FAIL sram_sel: got %0d cycles sel=%h want 2 cycles sel=01", sc, so);
    end
    n_checks++;
    if (np !== 1) begin n_fail++; $display("FAIL sram_pulse: got %0d pulses want 1", np); end
    n_checks++;
    if (m_rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL sram_rdata_hold: got %h want 12345678", m_rdata);
    end
  endtask

  task automatic test_led_write();
    int rc, sc, np; logic [31:0] rd, wd; logic [NS-1:0] so; logic [3:0] ws;
    run_txn(32'h8000_0000, 32'h0000_003F, 4'h1, 1, 1, 32'h0, rc, rd, sc, so, np, wd, ws);
    n_checks++;
    if (so !== 8'h02) begin n_fail++; $display("FAIL led_sel: got %h want 02", so); end
    n_checks++;
    if (wd !== 32'h3F || ws !== 4'h1) begin
      n_fail++; $display("FAIL led_wdata: got wdata=%h wstrb=%h want 3f/1", wd, ws);
    end
    n_checks++;
    if (np !== 1 || rc !== 2) begin
      n_fail++; $display("FAIL led_ready: got %0d pulses at cycle %0d want 1 at 2", np, rc);
    end
  endtask

  task automatic test_unmapped();
    int rc, sc, np; logic [31:0] rd, wd; logic [NS-1:0] so; logic [3:0] ws;
    run_txn(32'h9000_0000, 32'h0, 4'h0, -1, 0, 32'h0, rc, rd, sc, so, np, wd, ws);
    n_checks++;
    if (rc !== 17) begin n_fail++; $display("FAIL unmapped_latency: got %0d want 17", rc); end
    n_checks++;
    if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL unmapped_rdata: got %h want deadbeef", rd); end
    n_checks++;
    if (sc !== 0) begin n_fail++; $display("FAIL unmapped_sel: got %0d sel cycles want 0", sc); end
  endtask

  task automatic test_overlap();
    int rc, sc, np; logic [31:0] rd, wd; logic [NS-1:0] so; logic [3:0] ws;
    run_txn(32'h8000_0024, 32'h0, 4'h0, 5, 1, 32'h5555_5555, rc, rd, sc, so, np, wd, ws);
    n_checks++;
    if (so !== 8'h04) begin n_fail++; $display("FAIL overlap_sel: got %h want 04", so); end
    n_checks++;
    if (rc !== 17 || rd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL overlap_unsel_ready: got cycle %0d rdata %h want 17/deadbeef", rc, rd);
    end
    run_txn(32'h8000_0024, 32'h0, 4'h0, 2, 1, 32'h2222_0002, rc, rd, sc, so, np, wd, ws);
    n_checks++;
    if (rc !== 2 || rd !== 32'h2222_0002) begin
      n_fail++; $display("FAIL overlap_slave2: got cycle %0d rdata %h want 2/22220002", rc, rd);
    end
  endtask

  task automatic test_back_to_back();
    int rc, sc, np; logic [31:0] rd, wd; logic [NS-1:0] so; logic [3:0] ws;
    run_txn(32'h0000_0200, 32'h0, 4'h0, 0, 1, 32'hA0A0_0001, rc, rd, sc, so, np, wd, ws);
    n_checks++;
    if (rc !== 2 || rd !== 32'hA0A0_0001) begin
      n_fail++; $display("FAIL b2b_first: got cycle %0d rdata %h want 2/a0a00001", rc, rd);
    end
    run_txn(32'h0000_0204, 32'hCAFE_0000, 4'hF, 0, 1, 32'hB0B0_0002, rc, rd, sc, so, np, wd, ws);
    n_checks++;
    if (rc !== 2 || rd !== 32'hB0B0_0002 || wd !== 32'hCAFE_0000 || ws !== 4'hF) begin
      n_fail++; $display("FAIL b2b_second: got cycle %0d rdata %h wdata %h wstrb %h want 2/b0b00002/cafe0000/f",
                         rc, rd, wd, ws);
    end
    n_checks++;
    if (s_addr !== 32'h0000_0204) begin n_fail++; $display("FAIL b2b_addr: got %h want 00000204", s_addr); end
  endtask

  task automatic test_reset_mid();
    int rc, sc, np; int seen; logic [31:0] rd, wd; logic [NS-1:0] so; logic [3:0] ws;
    m_valid = 1'b1; m_addr = 32'h0000_0104; m_wdata = 32'h0000_0055; m_wstrb = 4'hF;
    tick();                       // cycle 1: ACCESS
    m_valid = 1'b0;
    tick();                       // cycle 2: ACCESS, reset sampled at its end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({m_ready, m_rdata, s_sel, s_addr, s_wdata, s_wstrb} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got m_ready=%0b m_rdata=%h s_sel=%h s_addr=%h s_wdata=%h s_wstrb=%h, want all 0",
               m_ready, m_rdata, s_sel, s_addr, s_wdata, s_wstrb);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m_ready) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL reset_mid_no_ready: got %0d pulses want 0", seen); end
    run_txn(32'h0000_0108, 32'h0, 4'h0, 0, 2, 32'h0BAD_F00D, rc, rd, sc, so, np, wd, ws);
    n_checks++;
    if (rc !== 3 || rd !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL reset_mid_recover: got cycle %0d rdata %h want 3/0badf00d", rc, rd);
    end
  endtask

`ifdef MMIO_ERR_STATUS_EN
  task automatic test_err_status();
    int rc, sc, np; logic [31:0] rd, wd; logic [NS-1:0] so; logic [3:0] ws;
    reset = 1'b1; tick(); reset = 1'b0;
    run_txn(32'h9000_0000, 32'h0, 4'h0, -1, 0, 32'h0, rc, rd, sc, so, np, wd, ws);
    run_txn(32'h9000_0004, 32'h0, 4'h0, -1, 0, 32'h0, rc, rd, sc, so, np, wd, ws);
    run_txn(32'h9000_0ABC, 32'h0, 4'h0, -1, 0, 32'h0, rc, rd, sc, so, np, wd, ws);
    run_txn(32'h8000_0040, 32'h0, 4'h0, -1, 0, 32'h0, rc, rd, sc, so, np, wd, ws);
    n_checks++;
    if (rc !== 2 || rd !== 32'h000A_BC03) begin
      n_fail++; $display("FAIL err_status_read: got cycle %0d rdata %h want 2/000abc03", rc, rd);
    end
    run_txn(32'h8000_0040, 32'h1, 4'hF, -1, 0, 32'h0, rc, rd, sc, so, np, wd, ws);
    run_txn(32'h8000_0040, 32'h0, 4'h0, -1, 0, 32'h0, rc, rd, sc, so, np, wd, ws);
    n_checks++;
    if (rc !== 2 || rd !== 32'h0) begin
      n_fail++; $display("FAIL err_status_clear: got cycle %0d rdata %h want 2/0", rc, rd);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef MMIO_ERR_STATUS_EN
    test_err_status();
`endif
    test_sram_read();
    test_led_write();
    test_unmapped();
    test_overlap();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
